apply_convolution_mul_arbiter: RTL and testbench

APPLY_CONVOLUTION_MUL_ARBITER -- requirements
Module: apply_convolution_mul_arbiter

---
 rtl/apply_convolution_mul_arbiter.sv | 96 +++++++++
 tb/tb_apply_convolution_mul_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apply_convolution_mul_arbiter.sv
// Two-requester round-robin front end for a shared pipelined multiplier.
// A valid/id shadow pipeline tracks each multiplier stage, so every product returns tagged with the requester that issued it.
module apply_convolution_mul_arbiter #(
  parameter int DIN0_WIDTH = 31,
  parameter int DIN1_WIDTH = 32,
  parameter int DOUT_WIDTH = 63,
  parameter int NUM_STAGE  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DIN0_WIDTH-1:0] req0_a,
  input  logic [DIN1_WIDTH-1:0] req0_b,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DIN0_WIDTH-1:0] req1_a,
  input  logic [DIN1_WIDTH-1:0] req1_b,
  output logic                  mul_ce,
  output logic [DIN0_WIDTH-1:0] mul_din0,
  output logic [DIN1_WIDTH-1:0] mul_din1,
  input  logic [DOUT_WIDTH-1:0] mul_dout,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DOUT_WIDTH-1:0] res_data,
  output logic                  res_id,
  output logic [15:0]           issue_cnt
);

  logic [NUM_STAGE-1:0] vld_q, vld_d;
  logic [NUM_STAGE-1:0] id_q, id_d;
  logic                 ptr_q, ptr_d;
  logic [15:0]          cnt_q, cnt_d;
  logic                 gnt0, gnt1, gnt_any, accept;

  assign res_valid = vld_q[NUM_STAGE-1];
  assign res_id    = id_q[NUM_STAGE-1];
  assign res_data  = mul_dout;
  assign issue_cnt = cnt_q;

  // A held result freezes the multiplier and the shadow pipeline together.
  assign mul_ce = ~(res_valid & ~res_ready);

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (ptr_q) begin
      if (req1_valid)      gnt1 = 1'b1;
      else if (req0_valid) gnt0 = 1'b1;
    end else begin
      if (req0_valid)      gnt0 = 1'b1;
      else if (req1_valid) gnt1 = 1'b1;
    end
  end

  assign gnt_any    = gnt0 | gnt1;
  assign accept     = gnt_any & mul_ce;
  assign req0_ready = gnt0 & mul_ce;
  assign req1_ready = gnt1 & mul_ce;
  assign mul_din0   = gnt1 ? req1_a : req0_a;
  assign mul_din1   = gnt1 ? req1_b : req0_b;

  always_comb begin
    vld_d = vld_q;
    id_d  = id_q;
    if (mul_ce) begin
      for (int i = NUM_STAGE - 1; i > 0; i--) begin
        vld_d[i] = vld_q[i-1];
        id_d[i]  = id_q[i-1];
      end
      vld_d[0] = gnt_any;
      id_d[0]  = gnt1;
    end
  end

  // Pointer moves to the losing side, so a continuously valid pair alternates.
  assign ptr_d = accept ? gnt0 : ptr_q;
  assign cnt_d = cnt_q + {15'd0, accept};

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      ptr_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    id_q <= id_d;
  end

endmodule

// File: tb/tb_apply_convolution_mul_arbiter.sv
// Bench for apply_convolution_mul_arbiter: a behavioural multiplier plus a queue-based
// reference model predicting grants, counts and the ordered result stream.
module tb_apply_convolution_mul_arbiter;
  localparam int W0 = 31;
  localparam int W1 = 32;
  localparam int WO = 63;
  localparam int NS = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_ready, req1_ready;
  logic [W0-1:0] req0_a = '0, req1_a = '0;
  logic [W1-1:0] req0_b = '0, req1_b = '0;
  logic          mul_ce;
  logic [W0-1:0] mul_din0;
  logic [W1-1:0] mul_din1;
  logic [WO-1:0] mul_dout;
  logic          res_valid;
  logic          res_ready = 1'b1;
  logic [WO-1:0] res_data;
  logic          res_id;
  logic [15:0]   issue_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  apply_convolution_mul_arbiter #(
    .DIN0_WIDTH(W0), .DIN1_WIDTH(W1), .DOUT_WIDTH(WO), .NUM_STAGE(NS)
  ) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .mul_ce(mul_ce), .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_dout(mul_dout),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id),
    .issue_cnt(issue_cnt)
  );

  // Behavioural NS-stage multiplier, advancing only when enabled.
  logic [WO-1:0] mstage [NS];
  always @(posedge clk) begin
    if (mul_ce) begin
      for (int i = NS - 1; i > 0; i--) mstage[i] <= mstage[i-1];
      mstage[0] <= mulw(mul_din0, mul_din1);
    end
  end
  assign mul_dout = mstage[NS-1];

  function automatic logic [WO-1:0] mulw(input logic [W0-1:0] a, input logic [W1-1:0] b);
    logic [WO-1:0] x, y;
    x = WO'(a);
    y = WO'(b);
    return x * y;
  endfunction

  // Reference model: in-flight results in issue order, each with enabled edges left before it shows.
  typedef struct {
    logic          id;
    logic [WO-1:0] prod;
    int            rem;
  } ent_t;
  ent_t        q[$];
  logic        ptr_m = 1'b0;
  logic [15:0] cnt_m = '0;

  logic          exp_valid, exp_id, exp_ce, exp_gnt, exp_w, exp_r0, exp_r1;
  logic [WO-1:0] exp_data, exp_prod;
  logic [W0-1:0] exp_din0;
  logic [W1-1:0] exp_din1;

  task automatic eval();
    #1;
    exp_valid = (q.size() > 0) && (q[0].rem == 0);
    exp_id    = exp_valid ? q[0].id : 1'b0;
    exp_data  = exp_valid ? q[0].prod : '0;
    exp_ce    = !(exp_valid && !res_ready);
    exp_gnt   = 1'b1;
    if (ptr_m == 1'b0) exp_w = req0_valid ? 1'b0 : 1'b1;
    else               exp_w = req1_valid ? 1'b1 : 1'b0;
    if (!req0_valid && !req1_valid) begin
      exp_gnt = 1'b0;
      exp_w   = 1'b0;
    end
    exp_r0   = exp_gnt && (exp_w == 1'b0) && exp_ce;
    exp_r1   = exp_gnt && (exp_w == 1'b1) && exp_ce;
    exp_din0 = exp_w ? req1_a : req0_a;
    exp_din1 = exp_w ? req1_b : req0_b;
    exp_prod = exp_w ? mulw(req1_a, req1_b) : mulw(req0_a, req0_b);
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      q.delete();
      ptr_m = 1'b0;
      cnt_m = '0;
    end else if (exp_ce) begin
      if (exp_valid) void'(q.pop_front());
      foreach (q[i]) if (q[i].rem > 0) q[i].rem--;
      if (exp_r0 || exp_r1) begin
        q.push_back('{id: exp_w, prod: exp_prod, rem: NS - 1});
        ptr_m = ~exp_w;
        cnt_m = cnt_m + 16'd1;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    res_ready = 1'b1;
    eval();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    eval();
    checks++;
    if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %0b expected 0", res_valid); end
    checks++;
    if (issue_cnt !== 16'd0) begin errors++; $display("FAIL reset_issue_cnt: got %0d expected 0", issue_cnt); end
    checks++;
    if (mul_ce !== 1'b1 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL reset_handshake: got ce=%0b r0=%0b r1=%0b expected 1 0 0", mul_ce, req0_ready, req1_ready);
    end
  endtask

  task automatic test_single();
    req0_valid = 1'b1; req0_a = W0'(3); req0_b = W1'(5); res_ready = 1'b1;
    eval();
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL single_accept: got r0=%0b r1=%0b expected 1 0", req0_ready, req1_ready);
    end
    checks++;
    if (mul_din0 !== W0'(3) || mul_din1 !== W1'(5)) begin
      errors++; $display("FAIL single_din: got %0d %0d expected 3 5", mul_din0, mul_din1);
    end
    tick();
    req0_valid = 1'b0;
    eval();
    checks++;
    if (res_valid !== 1'b0) begin errors++; $display("FAIL single_early: got res_valid=%0b expected 0", res_valid); end
    tick();
    eval();
    checks++;
    if (res_valid !== 1'b1 || res_data !== WO'(15) || res_id !== 1'b0) begin
      errors++; $display("FAIL single_result: got v=%0b d=%0d id=%0b expected 1 15 0", res_valid, res_data, res_id);
    end
    tick();
    eval();
    checks++;
    if (res_valid !== 1'b0) begin errors++; $display("FAIL single_once: got res_valid=%0b expected 0", res_valid); end
  endtask

  task automatic test_contention();
    logic [WO-1:0] got_d[$];
    logic          got_id[$];
    do_reset();
    req0_a = W0'(2); req0_b = W1'(2);
    req1_a = W0'(7); req1_b = W1'(9);
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      eval();
      checks++;
      if (req0_ready !== ((c % 2) == 0) || req1_ready !== ((c % 2) == 1)) begin
        errors++; $display("FAIL contention_grant[%0d]: got r0=%0b r1=%0b expected %0b %0b", c, req0_ready, req1_ready, (c % 2) == 0, (c % 2) == 1);
      end
      if (res_valid) begin got_d.push_back(res_data); got_id.push_back(res_id); end
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      eval();
      if (res_valid) begin got_d.push_back(res_data); got_id.push_back(res_id); end
      tick();
    end
    checks++;
    if (got_d.size() != 6) begin errors++; $display("FAIL contention_count: got %0d results expected 6", got_d.size()); end
    foreach (got_d[i]) begin
      checks++;
      if (got_d[i] !== ((i % 2) == 0 ? WO'(4) : WO'(63)) || got_id[i] !== ((i % 2) == 1)) begin
        errors++; $display("FAIL contention_result[%0d]: got d=%0d id=%0b expected %0d %0b", i, got_d[i], got_id[i], (i % 2) == 0 ? 4 : 63, (i % 2) == 1);
      end
    end
    eval();
    checks++;
    if (issue_cnt !== 16'd6) begin errors++; $display("FAIL contention_cnt: got %0d expected 6", issue_cnt); end
  endtask

  task automatic test_backpressure();
    do_reset();
    req0_valid = 1'b1; req0_a = W0'(11); req0_b = W1'(13);
    eval(); tick();
    req0_valid = 1'b0; req1_valid = 1'b1; req1_a = W0'(17); req1_b = W1'(19);
    eval(); tick();
    res_ready = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      eval();
      checks++;
      if (mul_ce !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        errors++; $display("FAIL stall_ctrl[%0d]: got ce=%0b r0=%0b r1=%0b expected 0 0 0", c, mul_ce, req0_ready, req1_ready);
      end
      checks++;
      if (res_valid !== 1'b1 || res_data !== WO'(143) || res_id !== 1'b0 || issue_cnt !== 16'd2) begin
        errors++; $display("FAIL stall_hold[%0d]: got v=%0b d=%0d id=%0b cnt=%0d expected 1 143 0 2", c, res_valid, res_data, res_id, issue_cnt);
      end
      tick();
    end
    res_ready = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    eval();
    checks++;
    if (res_valid !== 1'b1 || res_data !== WO'(143) || res_id !== 1'b0) begin
      errors++; $display("FAIL release_first: got v=%0b d=%0d id=%0b expected 1 143 0", res_valid, res_data, res_id);
    end
    tick();
    eval();
    checks++;
    if (res_valid !== 1'b1 || res_data !== WO'(323) || res_id !== 1'b1) begin
      errors++; $display("FAIL release_second: got v=%0b d=%0d id=%0b expected 1 323 1", res_valid, res_data, res_id);
    end
    tick();
    eval();
    checks++;
    if (res_valid !== 1'b0) begin errors++; $display("FAIL release_drained: got res_valid=%0b expected 0", res_valid); end
  endtask

  task automatic test_max_operands();
    bit seen = 0;
    req0_valid = 1'b1; req0_a = '1; req0_b = '1; res_ready = 1'b1;
    eval();
    checks++;
    if (req0_ready !== 1'b1) begin errors++; $display("FAIL max_accept: got r0=%0b expected 1", req0_ready); end
    tick();
    req0_valid = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      eval();
      if (res_valid) begin
        seen = 1;
        checks++;
        if (res_data !== 63'h7FFF_FFFE_8000_0001) begin
          errors++; $display("FAIL max_product: got %0h expected 7ffffffe80000001", res_data);
        end
      end
      tick();
    end
    if (!seen) begin checks++; errors++; $display("FAIL max_timeout: got no res_valid expected one"); end
  endtask

  task automatic test_reset_midflight();
    bit seen = 0;
    req0_a = W0'(100); req0_b = W1'(3); req1_a = W0'(200); req1_b = W1'(3);
    req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b1;
    eval(); tick();
    eval(); tick();
    reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    eval(); tick();
    reset = 1'b0;
    eval();
    checks++;
    if (res_valid !== 1'b0 || issue_cnt !== 16'd0) begin
      errors++; $display("FAIL midreset_clear: got v=%0b cnt=%0d expected 0 0", res_valid, issue_cnt);
    end
    req0_a = W0'(6); req0_b = W1'(7); req1_a = W0'(8); req1_b = W1'(9);
    req0_valid = 1'b1; req1_valid = 1'b1;
    eval();
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL midreset_ptr: got r0=%0b r1=%0b expected 1 0", req0_ready, req1_ready);
    end
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      eval();
      if (res_valid) begin
        seen = 1;
        checks++;
        if (res_data !== WO'(42) || res_id !== 1'b0) begin
          errors++; $display("FAIL midreset_first: got d=%0d id=%0b expected 42 0", res_data, res_id);
        end
      end
      tick();
    end
    if (!seen) begin checks++; errors++; $display("FAIL midreset_timeout: got no res_valid expected one"); end
    for (int c = 0; c < 4; c++) begin eval(); tick(); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      reset      = ($urandom_range(0, 99) == 0);
      req0_valid = ($urandom_range(0, 9) < 6);
      req1_valid = ($urandom_range(0, 9) < 6);
      res_ready  = ($urandom_range(0, 3) != 0);
      req0_a = ($urandom_range(0, 7) == 0) ? '1 : W0'($urandom());
      req0_b = ($urandom_range(0, 7) == 0) ? '1 : W1'($urandom());
      req1_a = W0'($urandom());
      req1_b = W1'($urandom());
      eval();
      checks++;
      if (res_valid !== exp_valid || (exp_valid && (res_data !== exp_data || res_id !== exp_id))) begin
        errors++; $display("FAIL rand_result[%0d]: got v=%0b d=%0h id=%0b expected %0b %0h %0b", c, res_valid, res_data, res_id, exp_valid, exp_data, exp_id);
      end
      checks++;
      if (mul_ce !== exp_ce || req0_ready !== exp_r0 || req1_ready !== exp_r1) begin
        errors++; $display("FAIL rand_handshake[%0d]: got ce=%0b r0=%0b r1=%0b expected %0b %0b %0b", c, mul_ce, req0_ready, req1_ready, exp_ce, exp_r0, exp_r1);
      end
      checks++;
      if (mul_din0 !== exp_din0 || mul_din1 !== exp_din1) begin
        errors++; $display("FAIL rand_din[%0d]: got %0h %0h expected %0h %0h", c, mul_din0, mul_din1, exp_din0, exp_din1);
      end
      checks++;
      if (issue_cnt !== cnt_m) begin
        errors++; $display("FAIL rand_cnt[%0d]: got %0d expected %0d", c, issue_cnt, cnt_m);
      end
      tick();
    end
    reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin eval(); tick(); end
  endtask

  task automatic test_wrap();
    do_reset();
    req0_valid = 1'b1; req1_valid = 1'b0; res_ready = 1'b1;
    for (int c = 0; c < 65535; c++) begin
      req0_a = W0'($urandom());
      req0_b = W1'($urandom());
      eval();
      tick();
    end
    eval();
    checks++;
    if (issue_cnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload: got %0h expected ffff", issue_cnt); end
    checks++;
    if (res_valid !== 1'b1 || res_data !== exp_data) begin
      errors++; $display("FAIL wrap_stream: got v=%0b d=%0h expected 1 %0h", res_valid, res_data, exp_data);
    end
    tick();
    req0_valid = 1'b0;
    eval();
    checks++;
    if (issue_cnt !== 16'h0000) begin errors++; $display("FAIL wrap_rollover: got %0h expected 0", issue_cnt); end
    for (int c = 0; c < 4; c++) begin eval(); tick(); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_max_operands();
    test_reset_midflight();
    test_random();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
